// File: rtl/icache_responder.sv
// icache_responder: direct-mapped, one-word-per-frame instruction cache.
// Answers datapath fetches (imemREN/imemaddr -> ihit/imemload) with
// zero-cycle hit latency and, on a miss, reads the word from the memory
// controller (iREN/iaddr <- iwait/iload) and fills the frame.
//
// Ports:
//   CLK, nRST          clock (rising edge), async active-low reset
//   imemREN, imemaddr  fetch request and byte address (bits [1:0] ignored)
//   ihit, imemload     fetch data valid and instruction word
//   flush              invalidate all frames
//   iREN, iaddr        memory read request and word-aligned address
//   iwait, iload       memory busy and read data
//   miss_count         saturating count of misses since reset

// One cache frame: valid bit with reset, tag and data without.
// Ports: CLK/nRST, flush (clear valid), we/wtag/wdata (fill), valid/tag/data.
module icache_frame #(
  parameter int TAG_W = 26
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             we,
  input  logic [TAG_W-1:0] wtag,
  input  logic [31:0]      wdata,
  output logic             valid,
  output logic [TAG_W-1:0] tag,
  output logic [31:0]      data
);
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)      valid <= 1'b0;
    else if (flush) valid <= 1'b0;
    else if (we)    valid <= 1'b1;
  end

  // Tag/data are only meaningful while valid, so they need no reset.
  always_ff @(posedge CLK) begin
    if (we) begin
      tag  <= wtag;
      data <= wdata;
    end
  end
endmodule

module icache_responder #(
  parameter int SETS  = 16,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  output logic             ihit,
  output logic [31:0]      imemload,
  input  logic             flush,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic             iwait,
  input  logic [31:0]      iload,
  output logic [CNT_W-1:0] miss_count
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
  } line_addr_t;

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t     state, state_nxt;
  line_addr_t req, miss_addr;

  logic [SETS-1:0]            f_valid;
  logic [SETS-1:0][TAG_W-1:0] f_tag;
  logic [SETS-1:0][31:0]      f_data;

  logic lookup_hit, miss_start, fill;
  logic unused_byte_sel;

  assign req             = imemaddr[31:2];
  assign unused_byte_sel = ^imemaddr[1:0];

  assign lookup_hit = f_valid[req.idx] && (f_tag[req.idx] == req.tag);
  // flush blocks miss entry so a flushed cycle never starts a fill.
  assign miss_start = (state == IDLE) && imemREN && !flush && !lookup_hit;
  // flush in FETCH aborts the fill: the frame is left invalid.
  assign fill       = (state == FETCH) && !iwait && !flush;

  for (genvar g = 0; g < SETS; g++) begin : g_frame
    icache_frame #(.TAG_W(TAG_W)) u_frame (
      .CLK   (CLK),
      .nRST  (nRST),
      .flush (flush),
      .we    (fill && (miss_addr.idx == IDX_W'(g))),
      .wtag  (miss_addr.tag),
      .wdata (iload),
      .valid (f_valid[g]),
      .tag   (f_tag[g]),
      .data  (f_data[g])
    );
  end

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (miss_start)      state_nxt = FETCH;
      FETCH:   if (flush || !iwait) state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ihit     = 1'b0;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = '0;
    case (state)
      IDLE: begin
        ihit     = imemREN && !flush && lookup_hit;
        imemload = ihit ? f_data[req.idx] : '0;
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = {miss_addr, 2'b00};
      end
      default: ;
    endcase
  end

  // Miss address latch and saturating miss counter; both advance only on
  // the IDLE->FETCH transition, so wait cycles never double-count.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      miss_addr  <= '0;
      miss_count <= '0;
    end else if (miss_start) begin
      miss_addr <= req;
      if (miss_count != '1) miss_count <= miss_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_icache_responder.sv
module tb_icache_responder;
  localparam int SETS  = 16;
  localparam int CNT_W = 16;

  logic             CLK = 1'b0;
  logic             nRST, imemREN, flush, iwait;
  logic [31:0]      imemaddr, iload;
  logic             ihit, iREN;
  logic [31:0]      imemload, iaddr;
  logic [CNT_W-1:0] miss_count;

  icache_responder #(.SETS(SETS), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .flush(flush), .iREN(iREN),
    .iaddr(iaddr), .iwait(iwait), .iload(iload), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: the cache contents as plain arrays, plus a miss tally.
  bit          m_valid [SETS];
  logic [31:0] m_tag   [SETS];
  logic [31:0] m_data  [SETS];
  int          m_count;

  function automatic int idx_of(logic [31:0] a);
    return int'((a / 4) % SETS);
  endfunction

  function automatic logic [31:0] tag_of(logic [31:0] a);
    return a / (4 * SETS);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < SETS; k++) m_valid[k] = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Sample all outputs mid-cycle against the expected values.
  task automatic check_cycle(input string t, input logic eh, input logic [31:0] eload,
                             input logic eren, input logic [31:0] eaddr);
    @(negedge CLK);
    chk({t, ".ihit"},       32'(ihit),       32'(eh));
    chk({t, ".imemload"},   imemload,        eload);
    chk({t, ".iREN"},       32'(iREN),       32'(eren));
    chk({t, ".iaddr"},      iaddr,           eaddr);
    chk({t, ".miss_count"}, 32'(miss_count), 32'(m_count));
  endtask

  // One fetch of address a. On a miss, memory answers after 'waits' busy
  // cycles with word d, and the re-presented address must then hit.
  task automatic fetch(input logic [31:0] a, input int waits, input logic [31:0] d);
    int   i;
    logic hit;
    i   = idx_of(a);
    hit = m_valid[i] && (m_tag[i] == tag_of(a));
    imemREN  = 1'b1;
    imemaddr = a;
    flush    = 1'b0;
    if (hit) begin
      check_cycle("hit", 1'b1, m_data[i], 1'b0, 32'h0);
      tick();
      return;
    end
    check_cycle("miss_req", 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    if (m_count < (1 << CNT_W) - 1) m_count++;
    for (int k = 0; k <= waits; k++) begin
      iwait = (k < waits);
      iload = (k < waits) ? $urandom : d;
      check_cycle("fetch", 1'b0, 32'h0, 1'b1, a & 32'hFFFF_FFFC);
      tick();
    end
    iwait     = 1'b1;
    m_valid[i] = 1'b1;
    m_tag[i]   = tag_of(a);
    m_data[i]  = d;
    check_cycle("refill_hit", 1'b1, d, 1'b0, 32'h0);
    tick();
  endtask

  task automatic flush_pulse(input logic [31:0] a, input logic ren);
    imemREN  = ren;
    imemaddr = a;
    flush    = 1'b1;
    check_cycle("flush", 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    flush   = 1'b0;
    imemREN = 1'b0;
    model_clear();
    check_cycle("post_flush", 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
  endtask

  initial begin
    logic [31:0] a, tg;
    int r;
    nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; flush = 1'b0;
    iwait = 1'b1; iload = '0;
    model_clear();
    m_count = 0;

    // Reset state
    #12;
    chk("rst.ihit",       32'(ihit),       32'h0);
    chk("rst.imemload",   imemload,        32'h0);
    chk("rst.iREN",       32'(iREN),       32'h0);
    chk("rst.iaddr",      iaddr,           32'h0);
    chk("rst.miss_count", 32'(miss_count), 32'h0);
    tick();
    nRST = 1'b1;
    tick();

    // 1: cold miss, 3 wait cycles
    fetch(32'h40, 3, 32'h2001_0005);
    chk("t1.miss_count", 32'(miss_count), 32'd1);

    // 2: hits, including a non-word-aligned address into the same frame
    fetch(32'h40, 0, 32'h0);
    fetch(32'h42, 0, 32'h0);
    chk("t2.miss_count", 32'(miss_count), 32'd1);

    // 3: conflict eviction on index 0
    fetch(32'h80, 1, 32'hCAFE_0080);
    fetch(32'h40, 2, 32'h2001_0005);
    chk("t3.miss_count", 32'(miss_count), 32'd3);

    // 4: flush invalidates everything
    fetch(32'h44, 0, 32'h1111_0044);
    flush_pulse(32'h40, 1'b1);
    fetch(32'h40, 1, 32'h2001_0005);
    fetch(32'h44, 0, 32'h1111_0044);
    chk("t4.miss_count", 32'(miss_count), 32'd6);

    // 5: flush in the second FETCH cycle aborts the fill
    imemREN = 1'b1; imemaddr = 32'h100;
    check_cycle("t5.req", 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    m_count++;
    iwait = 1'b1;
    check_cycle("t5.fetch1", 1'b0, 32'h0, 1'b1, 32'h100);
    tick();
    flush = 1'b1;
    iload = 32'hDEAD_0100;
    check_cycle("t5.fetch2", 1'b0, 32'h0, 1'b1, 32'h100);
    tick();
    flush = 1'b0; imemREN = 1'b0;
    model_clear();
    check_cycle("t5.abort", 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    fetch(32'h100, 0, 32'h5555_0100);

    // 6: reset mid-fetch
    imemREN = 1'b1; imemaddr = 32'h300;
    check_cycle("t6.req", 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    iwait = 1'b1;
    #1 nRST = 1'b0;
    #1;
    chk("t6.iREN",       32'(iREN),       32'h0);
    chk("t6.iaddr",      iaddr,           32'h0);
    chk("t6.ihit",       32'(ihit),       32'h0);
    chk("t6.miss_count", 32'(miss_count), 32'h0);
    m_count = 0;
    model_clear();
    tick();
    imemREN = 1'b0;
    nRST    = 1'b1;
    check_cycle("t6.idle", 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    fetch(32'h100, 0, 32'h5555_0100);
    fetch(32'h40,  1, 32'h2001_0005);

    // Random traffic over a small tag set, including the top index and
    // an all-ones tag, with occasional flushes and idle cycles.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 11);
      tg = ($urandom_range(0, 4) == 4) ? 32'h03FF_FFFF : 32'($urandom_range(0, 3));
      a = (tg * 4 * SETS) + ($urandom_range(0, SETS - 1) * 4) + $urandom_range(0, 3);
      if (r == 0) begin
        flush_pulse(a, 1'($urandom_range(0, 1)));
      end else if (r == 1) begin
        imemREN = 1'b0; imemaddr = a;
        check_cycle("idle", 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
      end else begin
        fetch(a, $urandom_range(0, 3), $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
